// File: rtl/pkt_port_demux_if.sv
// AXI-Stream bundle shared by the demux input and each of its output queues.
interface pkt_port_demux_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/pkt_port_demux.sv
// Routes each input packet to one of four output streams, chosen by the lowest
// set bit of the tuser destination field on the head beat; zero destination drops.
module pkt_port_demux #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_NUM_QUEUES       = 4,
  parameter int unsigned C_NUM_QUEUES_WIDTH = 2,
  parameter int unsigned C_DST_POS          = 24
) (
  input  logic               axis_clk,
  input  logic               aresetn,
  pkt_port_demux_if.slave    s_axis,
  pkt_port_demux_if.master   m_axis_0,
  pkt_port_demux_if.master   m_axis_1,
  pkt_port_demux_if.master   m_axis_2,
  pkt_port_demux_if.master   m_axis_3,
  output logic [31:0]        drop_cnt
);

  localparam int unsigned SEL_W  = C_NUM_QUEUES_WIDTH;
  localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [SEL_W-1:0]              r_sel;
  logic [SEL_W-1:0]              w_sel_nxt;
  logic [31:0]                   r_drop_cnt;
  logic                          w_drop_inc;

  logic [C_AXIS_DATA_WIDTH-1:0]  w_tdata;
  logic [KEEP_W-1:0]             w_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0] w_tuser;
  logic                          w_tlast;
  logic                          w_tvalid;

  logic [C_NUM_QUEUES-1:0]       w_dst;
  logic                          w_dst_ok;
  logic [SEL_W-1:0]              w_head_sel;
  logic [C_NUM_QUEUES-1:0]       w_m_tready;
  logic [C_NUM_QUEUES-1:0]       w_m_tvalid;
  logic                          w_s_tready;
  logic                          w_hs;

  // Lowest set bit wins when several destinations are flagged.
  function automatic logic [SEL_W-1:0] f_lowest(input logic [C_NUM_QUEUES-1:0] d);
    f_lowest = '0;
    for (int i = int'(C_NUM_QUEUES) - 1; i >= 0; i--) begin
      if (d[i]) f_lowest = SEL_W'(i);
    end
  endfunction

  assign w_tdata  = s_axis.tdata;
  assign w_tkeep  = s_axis.tkeep;
  assign w_tuser  = s_axis.tuser;
  assign w_tlast  = s_axis.tlast;
  assign w_tvalid = s_axis.tvalid;

  assign w_dst      = w_tuser[C_DST_POS +: C_NUM_QUEUES];
  assign w_dst_ok   = |w_dst;
  assign w_head_sel = f_lowest(w_dst);
  assign w_m_tready = {m_axis_3.tready, m_axis_2.tready, m_axis_1.tready, m_axis_0.tready};
  assign w_hs       = w_tvalid & w_s_tready;

  // State register; sel is only ever loaded from a head beat.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_drop_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (w_dst_ok) begin
            if (!w_tlast) begin
              w_state_nxt = S_FWD;
              w_sel_nxt   = w_head_sel;
            end
          end else if (w_tlast) begin
            w_drop_inc = 1'b1;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_FWD: begin
        if (w_hs && w_tlast) w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (w_hs && w_tlast) begin
          w_state_nxt = S_IDLE;
          w_drop_inc  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake steering; everything is held off while reset is asserted.
  always_comb begin
    w_s_tready = 1'b0;
    w_m_tvalid = '0;
    if (aresetn) begin
      case (r_state)
        S_IDLE: begin
          if (w_dst_ok) begin
            w_s_tready             = w_m_tready[w_head_sel];
            w_m_tvalid[w_head_sel] = w_tvalid;
          end else begin
            w_s_tready = 1'b1;
          end
        end
        S_FWD: begin
          w_s_tready        = w_m_tready[r_sel];
          w_m_tvalid[r_sel] = w_tvalid;
        end
        S_DROP:  w_s_tready = 1'b1;
        default: w_s_tready = 1'b0;
      endcase
    end
  end

  // Saturating count of dropped packets.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      r_drop_cnt <= '0;
    end else if (w_drop_inc && (r_drop_cnt != 32'hFFFF_FFFF)) begin
      r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign drop_cnt      = r_drop_cnt;
  assign s_axis.tready = w_s_tready;

  assign m_axis_0.tdata  = w_tdata;
  assign m_axis_0.tkeep  = w_tkeep;
  assign m_axis_0.tuser  = w_tuser;
  assign m_axis_0.tlast  = w_tlast;
  assign m_axis_0.tvalid = w_m_tvalid[0];

  assign m_axis_1.tdata  = w_tdata;
  assign m_axis_1.tkeep  = w_tkeep;
  assign m_axis_1.tuser  = w_tuser;
  assign m_axis_1.tlast  = w_tlast;
  assign m_axis_1.tvalid = w_m_tvalid[1];

  assign m_axis_2.tdata  = w_tdata;
  assign m_axis_2.tkeep  = w_tkeep;
  assign m_axis_2.tuser  = w_tuser;
  assign m_axis_2.tlast  = w_tlast;
  assign m_axis_2.tvalid = w_m_tvalid[2];

  assign m_axis_3.tdata  = w_tdata;
  assign m_axis_3.tkeep  = w_tkeep;
  assign m_axis_3.tuser  = w_tuser;
  assign m_axis_3.tlast  = w_tlast;
  assign m_axis_3.tvalid = w_m_tvalid[3];

endmodule

// File: tb/tb_pkt_port_demux.sv
// Scoreboard bench for pkt_port_demux: packets are queued per expected port at
// issue time, and a negedge monitor pops and compares every output handshake.
module tb_pkt_port_demux;

  localparam int unsigned DW   = 64;
  localparam int unsigned UW   = 32;
  localparam int unsigned KW   = DW / 8;
  localparam int unsigned DPOS = 24;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic        axis_clk = 1'b0;
  logic        aresetn  = 1'b0;
  logic [31:0] drop_cnt;

  pkt_port_demux_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  pkt_port_demux_if #(.DATA_W(DW), .USER_W(UW)) m0 ();
  pkt_port_demux_if #(.DATA_W(DW), .USER_W(UW)) m1 ();
  pkt_port_demux_if #(.DATA_W(DW), .USER_W(UW)) m2 ();
  pkt_port_demux_if #(.DATA_W(DW), .USER_W(UW)) m3 ();

  pkt_port_demux #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .C_NUM_QUEUES      (4),
    .C_NUM_QUEUES_WIDTH(2),
    .C_DST_POS         (DPOS)
  ) dut (
    .axis_clk(axis_clk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis_0(m0),
    .m_axis_1(m1),
    .m_axis_2(m2),
    .m_axis_3(m3),
    .drop_cnt(drop_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  logic [3:0] m_rdy = 4'hF;
  logic [3:0] stall_mask = 4'h0;
  bit         rand_rdy = 1'b0;
  logic [3:0] mv;
  beat_t      act [4];

  assign m0.tready = m_rdy[0];
  assign m1.tready = m_rdy[1];
  assign m2.tready = m_rdy[2];
  assign m3.tready = m_rdy[3];
  assign mv = {m3.tvalid, m2.tvalid, m1.tvalid, m0.tvalid};
  assign act[0] = {m0.tdata, m0.tkeep, m0.tuser, m0.tlast};
  assign act[1] = {m1.tdata, m1.tkeep, m1.tuser, m1.tlast};
  assign act[2] = {m2.tdata, m2.tkeep, m2.tuser, m2.tlast};
  assign act[3] = {m3.tdata, m3.tkeep, m3.tuser, m3.tlast};

  beat_t       exp_q [4][$];
  int          checks   = 0;
  int          errors   = 0;
  int          cur_port = -1;
  int unsigned exp_drop = 0;
  int          cyc      = 0;

  always @(posedge axis_clk) cyc <= cyc + 1;

  // Output readiness: random backpressure or a directed stall mask.
  always @(posedge axis_clk) begin
    #2;
    m_rdy = rand_rdy ? 4'($urandom) : ~stall_mask;
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // Monitor: routing, zero-latency tvalid, backpressure and beat content.
  always @(negedge axis_clk) begin
    if (aresetn) begin
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("tvalid_%0d", p), 128'(mv[p]),
            128'((p == cur_port) ? s_if.tvalid : 1'b0));
        if (mv[p] && m_rdy[p]) begin
          if (exp_q[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat port=%0d act=%0h exp=none", p, act[p]);
          end else begin
            chk($sformatf("beat_%0d", p), 128'(act[p]), 128'(exp_q[p].pop_front()));
          end
        end
      end
      if (s_if.tvalid)
        chk("s_tready", 128'(s_if.tready),
            128'((cur_port < 0) ? 1'b1 : m_rdy[cur_port]));
    end
  end

  task automatic drive_beat(input beat_t x);
    int n = 0;
    s_if.tdata  = x.d;
    s_if.tkeep  = x.k;
    s_if.tuser  = x.u;
    s_if.tlast  = x.l;
    s_if.tvalid = 1'b1;
    @(negedge axis_clk);
    while (!s_if.tready && n < 200) begin
      n++;
      @(negedge axis_clk);
    end
    if (!s_if.tready) begin
      checks++;
      errors++;
      $display("FAIL timeout act=tready_low exp=handshake t=%0t", $time);
    end
    @(posedge axis_clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  function automatic beat_t rand_beat();
    beat_t x;
    x.d = {$urandom, $urandom};
    x.k = KW'($urandom);
    x.u = $urandom;
    x.l = 1'b0;
    return x;
  endfunction

  // Reference model: target is the lowest set head-dst bit, or a drop if none.
  task automatic send_pkt(input logic [3:0] dst, input int n, input bit fix2, input logic [3:0] dst2);
    beat_t b[$];
    int port = -1;
    for (int i = 0; i < 4; i++) if (dst[i] && port < 0) port = i;
    for (int i = 0; i < n; i++) begin
      beat_t x = rand_beat();
      if (i == 0) x.u[DPOS +: 4] = dst;
      else if (fix2) x.u[DPOS +: 4] = dst2;
      x.l = (i == n - 1);
      b.push_back(x);
      if (port >= 0) exp_q[port].push_back(x);
    end
    if (port < 0) exp_drop++;
    cur_port = port;
    foreach (b[i]) drive_beat(b[i]);
  endtask

  initial begin
    beat_t      h;
    logic [3:0] d;
    int         c0;
    int         guard;

    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = 32'h0100_0000;
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_s_tready", 128'(s_if.tready), 128'(0));
    chk("rst_tvalid", 128'(mv), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    s_if.tvalid = 1'b0;
    aresetn     = 1'b1;
    @(posedge axis_clk);
    #1;

    send_pkt(4'b0100, 3, 1'b0, 4'b0000);
    send_pkt(4'b0110, 4, 1'b1, 4'b0001);
    send_pkt(4'b0000, 4, 1'b0, 4'b0000);
    chk("drop_after_zero_dst", 128'(drop_cnt), 128'(exp_drop));

    // Port 3 stalls for five cycles mid-packet.
    fork
      send_pkt(4'b1000, 6, 1'b0, 4'b0000);
      begin
        repeat (2) @(posedge axis_clk);
        #1 stall_mask = 4'b1000;
        repeat (5) @(posedge axis_clk);
        #1 stall_mask = 4'b0000;
      end
    join

    c0 = cyc;
    for (int p = 0; p < 4; p++) send_pkt(4'(1 << p), 1, 1'b0, 4'b0000);
    chk("b2b_cycles", 128'(cyc - c0), 128'(4));

    rand_rdy = 1'b1;
    repeat (60) begin
      repeat ($urandom_range(0, 2)) begin
        s_if.tuser = $urandom;
        @(posedge axis_clk);
        #1;
      end
      d = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      send_pkt(d, int'($urandom_range(1, 5)), 1'b0, 4'b0000);
    end
    rand_rdy = 1'b0;
    @(posedge axis_clk);
    #1;
    chk("drop_after_random", 128'(drop_cnt), 128'(exp_drop));

    // Reset lands on beat 2 of a packet heading to port 1.
    h = rand_beat();
    h.u[DPOS +: 4] = 4'b0010;
    exp_q[1].push_back(h);
    cur_port = 1;
    drive_beat(h);
    h = rand_beat();
    h.u[DPOS +: 4] = 4'b0000;
    s_if.tdata  = h.d;
    s_if.tkeep  = h.k;
    s_if.tuser  = h.u;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    aresetn     = 1'b0;
    @(negedge axis_clk);
    chk("rst_mid_tvalid", 128'(mv), 128'(0));
    chk("rst_mid_tready", 128'(s_if.tready), 128'(0));
    @(posedge axis_clk);
    #1;
    chk("rst_mid_drop_cnt", 128'(drop_cnt), 128'(0));
    exp_drop    = 0;
    s_if.tvalid = 1'b0;
    aresetn     = 1'b1;
    @(posedge axis_clk);
    #1;
    send_pkt(4'b1001, 2, 1'b0, 4'b0000);
    send_pkt(4'b0000, 1, 1'b0, 4'b0000);
    chk("drop_after_reset", 128'(drop_cnt), 128'(exp_drop));

    guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && guard < 100) begin
      guard++;
      @(posedge axis_clk);
    end
    for (int p = 0; p < 4; p++)
      chk($sformatf("drain_q%0d", p), 128'(exp_q[p].size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_port_demux.md
PKT_PORT_DEMUX -- requirements
Module: pkt_port_demux

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, AXIS data width.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, AXIS tuser width.
REQ-003 SHALL have parameter C_NUM_QUEUES, default 4, number of output ports.
REQ-004 SHALL have parameter C_NUM_QUEUES_WIDTH, default 2, log2 of C_NUM_QUEUES.
REQ-005 SHALL have parameter C_DST_POS, default 24, LSB position in tuser of the C_NUM_QUEUES-bit destination field.
REQ-006 SHALL have port axis_clk, in, 1, clock; all logic on rising edge.
REQ-007 SHALL have port aresetn, in, 1, reset, synchronous, active-low.
REQ-008 SHALL have ports s_axis_tdata / tkeep / tuser / tlast / tvalid, in, DATA / DATA/8 / TUSER / 1 / 1, single input stream.
REQ-009 SHALL have port s_axis_tready, out, 1, input backpressure.
REQ-010 SHALL have ports m_axis_tdata_N / tkeep_N / tuser_N / tlast_N / tvalid_N, out, same widths, N=0..3, one stream per output queue.
REQ-011 SHALL have ports m_axis_tready_N, in, 1, N=0..3, per-output backpressure.
REQ-012 SHALL have port drop_cnt, out, 32, count of dropped packets.

Function
REQ-013 SHALL decode dst = s_axis_tuser[C_DST_POS +: C_NUM_QUEUES] only on the first beat of a packet.
REQ-014 SHALL select the lowest set bit of dst as the target port; zero dst means drop the packet.
REQ-015 SHALL implement FSM states IDLE, FWD and DROP, with IDLE as the first-beat state.
REQ-016 In IDLE with valid dst: s_axis_tready = m_axis_tready_sel; tvalid_sel = s_axis_tvalid; the first beat passes with zero latency.
REQ-017 IDLE transitions: on handshake with tlast=0 go to FWD with sel latched; with tlast=1 stay in IDLE; with no handshake stay in IDLE and keep no sel.
REQ-018 In FWD: use the latched sel; tdata / tkeep / tuser / tlast broadcast to all outputs; only tvalid_sel is asserted; s_axis_tready = m_axis_tready_sel.
REQ-019 Non-selected m_axis_tvalid_N SHALL be 0 at all times; tuser changes on later beats SHALL NOT change sel.
REQ-020 FWD transitions: on handshake of a tlast beat go to IDLE; otherwise stay in FWD.
REQ-021 In IDLE with zero dst: s_axis_tready = 1, all m tvalid = 0, and the beat is consumed.
REQ-022 Zero-dst beat: if tlast=1, drop_cnt++ and stay in IDLE; if tlast=0, go to DROP.
REQ-023 In DROP: s_axis_tready = 1 and all m tvalid = 0; on a tlast beat, drop_cnt++ and go to IDLE.
REQ-024 drop_cnt SHALL saturate at 32'hFFFFFFFF with no wrap.
REQ-025 SHALL hold at most one packet in flight and add no buffering; a stalled selected port stalls the input with no head-of-line bypass.
REQ-026 SHALL NOT consume a beat without s_axis_tvalid and s_axis_tready both high in the same cycle.

Reset
REQ-027 While aresetn=0: state = IDLE, sel = 0, drop_cnt = 0, all m_axis_tvalid_N = 0, s_axis_tready = 0.
REQ-028 A reset mid-packet SHALL abandon the packet; the first beat after reset is decoded as a new packet head.

Verification
REQ-029 Scenario: a 3-beat packet with dst=4'b0100 and m_axis_tready_2=1 -> 3 beats on port 2, ports 0/1/3 tvalid always 0, then IDLE.
REQ-030 Scenario: dst=4'b0110 -> the packet goes to port 1 only; beat-2 tuser dst changed to 4'b0001 -> the packet stays on port 1.
REQ-031 Scenario: dst=0 on a 4-beat packet -> s_axis_tready=1 throughout, no m tvalid, drop_cnt 0->1 after the tlast beat.
REQ-032 Scenario: port 3 selected with m_axis_tready_3 held 0 for 5 cycles mid-packet -> s_axis_tready=0 for those 5 cycles, data held, no beats lost or duplicated.
REQ-033 Scenario: single-beat packets back-to-back to ports 0,1,2,3 -> one beat per cycle, each on the correct port, FSM stays in IDLE.
REQ-034 Scenario: aresetn pulled low during beat 2 of a FWD packet -> next cycle all tvalid = 0 and drop_cnt = 0; the next head beat is routed by its own dst.
